// File: rtl/dispatch_pkg.sv
// rtl/dispatch_pkg.sv - shared dispatch/issue widths and entry field layout
package dispatch_pkg;

    localparam int IQ_DATA_WIDTH   = 32;
    localparam int IQ_TAG_WIDTH    = 6;
    localparam int IQ_OPCODE_WIDTH = 4;

    // Field layout of one queue entry at the default widths.
    typedef struct packed {
        logic                       valid;
        logic [IQ_OPCODE_WIDTH-1:0] opcode;
        logic [IQ_TAG_WIDTH-1:0]    rd_tag;
        logic [IQ_TAG_WIDTH-1:0]    rs1_tag;
        logic                       rs1_valid;
        logic [IQ_DATA_WIDTH-1:0]   rs1_data;
        logic [IQ_TAG_WIDTH-1:0]    rs2_tag;
        logic                       rs2_valid;
        logic [IQ_DATA_WIDTH-1:0]   rs2_data;
    } iq_entry_t;

endpackage

// File: rtl/iq_select.sv
// rtl/iq_select.sv - lowest-index ready picker, one-hot grant plus any-ready
module iq_select #(
    parameter int DEPTH = 4
) (
    input  logic [DEPTH-1:0] ready,
    output logic [DEPTH-1:0] grant,
    output logic             any_ready
);

    // Two's-complement trick isolates the lowest set bit.
    assign grant     = ready & (~ready + DEPTH'(1));
    assign any_ready = |ready;

endmodule

// File: rtl/issue_queue.sv
// rtl/issue_queue.sv - collapsing in-order-age issue queue with CDB wakeup
module issue_queue
    import dispatch_pkg::*;
#(
    parameter int DATA_WIDTH   = IQ_DATA_WIDTH,
    parameter int TAG_WIDTH    = IQ_TAG_WIDTH,
    parameter int OPCODE_WIDTH = IQ_OPCODE_WIDTH,
    parameter int DEPTH        = 4,
    localparam int CW          = $clog2(DEPTH + 1)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    dispatch_en,
    input  logic [OPCODE_WIDTH-1:0] dispatch_opcode,
    input  logic [TAG_WIDTH-1:0]    dispatch_rd_tag,
    input  logic [DATA_WIDTH-1:0]   dispatch_rs1_data,
    input  logic [TAG_WIDTH-1:0]    dispatch_rs1_tag,
    input  logic                    dispatch_rs1_valid,
    input  logic [DATA_WIDTH-1:0]   dispatch_rs2_data,
    input  logic [TAG_WIDTH-1:0]    dispatch_rs2_tag,
    input  logic                    dispatch_rs2_valid,
    output logic                    issueque_full,
    output logic [CW-1:0]           issueque_count,
    input  logic                    CDB_valid,
    input  logic [TAG_WIDTH-1:0]    CDB_tag,
    input  logic [DATA_WIDTH-1:0]   CDB_data,
    input  logic                    flush,
    input  logic                    issue_ready,
    output logic                    issue_valid,
    output logic [OPCODE_WIDTH-1:0] issue_opcode,
    output logic [TAG_WIDTH-1:0]    issue_rd_tag,
    output logic [DATA_WIDTH-1:0]   issue_rs1_data,
    output logic [DATA_WIDTH-1:0]   issue_rs2_data
);

    logic [CW-1:0]           count_q, count_n, tail, sel_idx;
    logic [OPCODE_WIDTH-1:0] op_q [DEPTH], op_n [DEPTH];
    logic [TAG_WIDTH-1:0]    rd_q [DEPTH], rd_n [DEPTH];
    logic [TAG_WIDTH-1:0]    s1_tag_q [DEPTH], s1_tag_n [DEPTH];
    logic [TAG_WIDTH-1:0]    s2_tag_q [DEPTH], s2_tag_n [DEPTH];
    logic                    s1_v_q [DEPTH], s1_v_n [DEPTH], w_s1_v [DEPTH];
    logic                    s2_v_q [DEPTH], s2_v_n [DEPTH], w_s2_v [DEPTH];
    logic [DATA_WIDTH-1:0]   s1_d_q [DEPTH], s1_d_n [DEPTH], w_s1_d [DEPTH];
    logic [DATA_WIDTH-1:0]   s2_d_q [DEPTH], s2_d_n [DEPTH], w_s2_d [DEPTH];
    logic [DEPTH-1:0]        ready, grant;
    logic                    any_ready, fire, accept;
    logic                    d_s1_v, d_s2_v;
    logic [DATA_WIDTH-1:0]   d_s1_d, d_s2_d;

    // Occupancy is implied by count since entries are packed from index 0.
    always_comb begin
        ready = '0;
        for (int i = 0; i < DEPTH; i++) begin
            ready[i] = (CW'(i) < count_q) & s1_v_q[i] & s2_v_q[i];
        end
    end

    iq_select #(.DEPTH(DEPTH)) u_select (
        .ready     (ready),
        .grant     (grant),
        .any_ready (any_ready)
    );

    always_comb begin
        issue_opcode   = '0;
        issue_rd_tag   = '0;
        issue_rs1_data = '0;
        issue_rs2_data = '0;
        sel_idx        = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (grant[i]) begin
                issue_opcode   = issue_opcode | op_q[i];
                issue_rd_tag   = issue_rd_tag | rd_q[i];
                issue_rs1_data = issue_rs1_data | s1_d_q[i];
                issue_rs2_data = issue_rs2_data | s2_d_q[i];
                sel_idx        = CW'(i);
            end
        end
    end

    assign issue_valid    = any_ready;
    assign issueque_count = count_q;
    assign issueque_full  = (count_q == CW'(DEPTH));
    assign fire           = any_ready & issue_ready;
    assign accept         = dispatch_en & ~issueque_full;
    assign tail           = count_q - CW'(fire);
    assign count_n        = count_q + CW'(accept) - CW'(fire);

    // Dispatch-time bypass: an incoming source can be satisfied by this cycle's broadcast.
    assign d_s1_v = dispatch_rs1_valid | (CDB_valid & (dispatch_rs1_tag == CDB_tag));
    assign d_s2_v = dispatch_rs2_valid | (CDB_valid & (dispatch_rs2_tag == CDB_tag));
    assign d_s1_d = dispatch_rs1_valid ? dispatch_rs1_data : CDB_data;
    assign d_s2_d = dispatch_rs2_valid ? dispatch_rs2_data : CDB_data;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            w_s1_v[i] = s1_v_q[i];
            w_s1_d[i] = s1_d_q[i];
            w_s2_v[i] = s2_v_q[i];
            w_s2_d[i] = s2_d_q[i];
            if (CDB_valid && !s1_v_q[i] && s1_tag_q[i] == CDB_tag) begin
                w_s1_v[i] = 1'b1;
                w_s1_d[i] = CDB_data;
            end
            if (CDB_valid && !s2_v_q[i] && s2_tag_q[i] == CDB_tag) begin
                w_s2_v[i] = 1'b1;
                w_s2_d[i] = CDB_data;
            end
        end
    end

    // Collapse over the issued slot, then write the new entry at the tail.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            int src;
            src = i;
            if (fire && CW'(i) >= sel_idx) begin
                src = (i < DEPTH - 1) ? i + 1 : i;
            end
            op_n[i]     = op_q[src];
            rd_n[i]     = rd_q[src];
            s1_tag_n[i] = s1_tag_q[src];
            s2_tag_n[i] = s2_tag_q[src];
            s1_v_n[i]   = w_s1_v[src];
            s2_v_n[i]   = w_s2_v[src];
            s1_d_n[i]   = w_s1_d[src];
            s2_d_n[i]   = w_s2_d[src];
            if (accept && CW'(i) == tail) begin
                op_n[i]     = dispatch_opcode;
                rd_n[i]     = dispatch_rd_tag;
                s1_tag_n[i] = dispatch_rs1_tag;
                s2_tag_n[i] = dispatch_rs2_tag;
                s1_v_n[i]   = d_s1_v;
                s2_v_n[i]   = d_s2_v;
                s1_d_n[i]   = d_s1_d;
                s2_d_n[i]   = d_s2_d;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else if (flush) begin
            count_q <= '0;
        end else begin
            count_q <= count_n;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            op_q[i]     <= op_n[i];
            rd_q[i]     <= rd_n[i];
            s1_tag_q[i] <= s1_tag_n[i];
            s2_tag_q[i] <= s2_tag_n[i];
            s1_v_q[i]   <= s1_v_n[i];
            s2_v_q[i]   <= s2_v_n[i];
            s1_d_q[i]   <= s1_d_n[i];
            s2_d_q[i]   <= s2_d_n[i];
        end
    end

endmodule

// File: tb/tb_issue_queue.sv
// tb/tb_issue_queue.sv - randomized and directed checks of issue_queue against a queue model
module tb_issue_queue;
    import dispatch_pkg::*;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        dispatch_en;
    logic [3:0]  dispatch_opcode;
    logic [5:0]  dispatch_rd_tag;
    logic [31:0] dispatch_rs1_data;
    logic [5:0]  dispatch_rs1_tag;
    logic        dispatch_rs1_valid;
    logic [31:0] dispatch_rs2_data;
    logic [5:0]  dispatch_rs2_tag;
    logic        dispatch_rs2_valid;
    logic        issueque_full;
    logic [2:0]  issueque_count;
    logic        CDB_valid;
    logic [5:0]  CDB_tag;
    logic [31:0] CDB_data;
    logic        flush;
    logic        issue_ready;
    logic        issue_valid;
    logic [3:0]  issue_opcode;
    logic [5:0]  issue_rd_tag;
    logic [31:0] issue_rs1_data;
    logic [31:0] issue_rs2_data;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;
    iq_entry_t mq[$];

    issue_queue #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .dispatch_en(dispatch_en), .dispatch_opcode(dispatch_opcode),
        .dispatch_rd_tag(dispatch_rd_tag),
        .dispatch_rs1_data(dispatch_rs1_data), .dispatch_rs1_tag(dispatch_rs1_tag),
        .dispatch_rs1_valid(dispatch_rs1_valid),
        .dispatch_rs2_data(dispatch_rs2_data), .dispatch_rs2_tag(dispatch_rs2_tag),
        .dispatch_rs2_valid(dispatch_rs2_valid),
        .issueque_full(issueque_full), .issueque_count(issueque_count),
        .CDB_valid(CDB_valid), .CDB_tag(CDB_tag), .CDB_data(CDB_data),
        .flush(flush), .issue_ready(issue_ready),
        .issue_valid(issue_valid), .issue_opcode(issue_opcode),
        .issue_rd_tag(issue_rd_tag), .issue_rs1_data(issue_rs1_data),
        .issue_rs2_data(issue_rs2_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int model_sel();
        for (int i = 0; i < mq.size(); i++)
            if (mq[i].rs1_valid && mq[i].rs2_valid) return i;
        return -1;
    endfunction

    function automatic iq_entry_t wake(input iq_entry_t e);
        iq_entry_t r;
        r = e;
        if (CDB_valid) begin
            if (!r.rs1_valid && r.rs1_tag == CDB_tag) begin r.rs1_valid = 1'b1; r.rs1_data = CDB_data; end
            if (!r.rs2_valid && r.rs2_tag == CDB_tag) begin r.rs2_valid = 1'b1; r.rs2_data = CDB_data; end
        end
        return r;
    endfunction

    // Queue semantics: wake everyone, pop the oldest ready on handshake, append on dispatch.
    task automatic model_step();
        int s;
        bit fire, acc;
        iq_entry_t ne;
        s    = model_sel();
        fire = (s >= 0) && issue_ready;
        acc  = dispatch_en && (mq.size() < DEPTH);
        if (reset || flush) begin
            mq.delete();
        end else begin
            for (int i = 0; i < mq.size(); i++) mq[i] = wake(mq[i]);
            if (fire) mq.delete(s);
            if (acc) begin
                ne = '{valid: 1'b1, opcode: dispatch_opcode, rd_tag: dispatch_rd_tag,
                       rs1_tag: dispatch_rs1_tag, rs1_valid: dispatch_rs1_valid, rs1_data: dispatch_rs1_data,
                       rs2_tag: dispatch_rs2_tag, rs2_valid: dispatch_rs2_valid, rs2_data: dispatch_rs2_data};
                mq.push_back(wake(ne));
            end
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            int s;
            iq_entry_t e;
            s = model_sel();
            e = '0;
            if (s >= 0) e = mq[s];
            check("count", 64'(issueque_count), 64'(mq.size()));
            check("full", 64'(issueque_full), 64'(mq.size() == DEPTH));
            check("issue_valid", 64'(issue_valid), 64'(s >= 0));
            check("issue_opcode", 64'(issue_opcode), 64'(e.opcode));
            check("issue_rd_tag", 64'(issue_rd_tag), 64'(e.rd_tag));
            check("issue_rs1_data", 64'(issue_rs1_data), 64'(e.rs1_data));
            check("issue_rs2_data", 64'(issue_rs2_data), 64'(e.rs2_data));
        end
    end

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle();
        dispatch_en = 0; dispatch_opcode = 0; dispatch_rd_tag = 0;
        dispatch_rs1_data = 0; dispatch_rs1_tag = 0; dispatch_rs1_valid = 0;
        dispatch_rs2_data = 0; dispatch_rs2_tag = 0; dispatch_rs2_valid = 0;
        CDB_valid = 0; CDB_tag = 0; CDB_data = 0; flush = 0; issue_ready = 0;
    endtask

    task automatic disp(input logic [5:0] rd, input logic v1, input logic [5:0] t1, input logic [31:0] d1,
                        input logic v2, input logic [5:0] t2, input logic [31:0] d2);
        dispatch_en = 1; dispatch_opcode = rd[3:0]; dispatch_rd_tag = rd;
        dispatch_rs1_valid = v1; dispatch_rs1_tag = t1; dispatch_rs1_data = d1;
        dispatch_rs2_valid = v2; dispatch_rs2_tag = t2; dispatch_rs2_data = d2;
    endtask

    initial begin
        idle();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_count", 64'(issueque_count), 64'd0);
        check("rst_full", 64'(issueque_full), 64'd0);
        check("rst_issue_valid", 64'(issue_valid), 64'd0);
        check("rst_issue_data", 64'(issue_rs1_data | issue_rs2_data), 64'd0);
        reset = 1'b0;
        chk_en = 1'b1;

        // Fill to DEPTH with ready ops, overflow dispatch is dropped, then drain in age order.
        for (int t = 1; t <= 4; t++) begin
            disp(6'(t), 1, 0, 32'(100 + t), 1, 0, 32'(200 + t));
            cycle();
        end
        check("fill_count", 64'(issueque_count), 64'd4);
        check("fill_full", 64'(issueque_full), 64'd1);
        disp(6'd5, 1, 0, 32'd105, 1, 0, 32'd205);
        cycle();
        check("overflow_count", 64'(issueque_count), 64'd4);
        idle();
        issue_ready = 1;
        for (int t = 1; t <= 4; t++) begin
            check("drain_rd_tag", 64'(issue_rd_tag), 64'(t));
            cycle();
        end
        check("drain_empty", 64'(issueque_count), 64'd0);

        // Wakeup from CDB.
        idle();
        disp(6'd7, 0, 6'd5, 0, 1, 0, 32'h55);
        cycle();
        idle();
        check("wait_issue_valid", 64'(issue_valid), 64'd0);
        CDB_valid = 1; CDB_tag = 6'd5; CDB_data = 32'hDEADBEEF;
        cycle();
        idle();
        check("wake_valid", 64'(issue_valid), 64'd1);
        check("wake_rs1", 64'(issue_rs1_data), 64'hDEADBEEF);
        check("wake_rd", 64'(issue_rd_tag), 64'd7);
        issue_ready = 1;
        cycle();

        // Dispatch-time bypass.
        idle();
        disp(6'd8, 1, 0, 32'h11, 0, 6'd9, 0);
        CDB_valid = 1; CDB_tag = 6'd9; CDB_data = 32'h12345678;
        cycle();
        idle();
        check("bypass_valid", 64'(issue_valid), 64'd1);
        check("bypass_rs2", 64'(issue_rs2_data), 64'h12345678);
        issue_ready = 1;
        cycle();

        // Younger ready entry passes an older waiting one.
        idle();
        disp(6'd10, 0, 6'd11, 0, 1, 0, 32'hA);
        cycle();
        disp(6'd12, 1, 0, 32'hB, 1, 0, 32'hC);
        cycle();
        idle();
        check("ooo_rd", 64'(issue_rd_tag), 64'd12);
        issue_ready = 1;
        cycle();
        idle();
        check("ooo_count", 64'(issueque_count), 64'd1);
        check("ooo_wait", 64'(issue_valid), 64'd0);
        CDB_valid = 1; CDB_tag = 6'd11; CDB_data = 32'hFACE;
        cycle();
        idle();
        check("ooo_old_rd", 64'(issue_rd_tag), 64'd10);
        check("ooo_old_rs1", 64'(issue_rs1_data), 64'hFACE);
        issue_ready = 1;
        cycle();

        // Flush dominates dispatch and issue.
        idle();
        for (int t = 20; t < 23; t++) begin
            disp(6'(t), 1, 0, 32'(t), 1, 0, 32'(t));
            cycle();
        end
        check("pre_flush_count", 64'(issueque_count), 64'd3);
        disp(6'd30, 1, 0, 1, 1, 0, 1);
        flush = 1; issue_ready = 1;
        cycle();
        idle();
        check("flush_count", 64'(issueque_count), 64'd0);
        check("flush_valid", 64'(issue_valid), 64'd0);

        // Asynchronous reset between edges.
        for (int t = 40; t < 42; t++) begin
            disp(6'(t), 1, 0, 32'(t), 1, 0, 32'(t));
            cycle();
        end
        idle();
        check("pre_reset_count", 64'(issueque_count), 64'd2);
        #2;
        reset = 1'b1;
        #1;
        mq.delete();
        check("areset_full", 64'(issueque_full), 64'd0);
        check("areset_count", 64'(issueque_count), 64'd0);
        check("areset_valid", 64'(issue_valid), 64'd0);
        check("areset_data", 64'(issue_rs1_data), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        cycle();

        // Randomized traffic against the model.
        for (int n = 0; n < 2000; n++) begin
            dispatch_en        = ($urandom_range(0, 9) < 6);
            dispatch_opcode    = 4'($urandom);
            dispatch_rd_tag    = 6'($urandom);
            dispatch_rs1_valid = $urandom_range(0, 1) == 1;
            dispatch_rs1_tag   = 6'($urandom_range(0, 7));
            dispatch_rs1_data  = $urandom;
            dispatch_rs2_valid = $urandom_range(0, 1) == 1;
            dispatch_rs2_tag   = 6'($urandom_range(0, 7));
            dispatch_rs2_data  = $urandom;
            CDB_valid          = ($urandom_range(0, 9) < 4);
            CDB_tag            = 6'($urandom_range(0, 7));
            CDB_data           = $urandom;
            flush              = ($urandom_range(0, 99) < 3);
            issue_ready        = ($urandom_range(0, 9) < 7);
            cycle();
        end
        idle();
        cycle();
        chk_en = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/issue_queue.md
ISSUE_QUEUE -- requirements
Module: issue_queue

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, the operand data width.
REQ-002 SHALL have parameter TAG_WIDTH, default 6, the rename/CDB tag width.
REQ-003 SHALL have parameter OPCODE_WIDTH, default 4, the dispatch opcode width.
REQ-004 SHALL have parameter DEPTH, default 4 (legal 2..16), the number of queue entries.
REQ-005 SHALL have ports clk (input, 1, the single clock) and reset (input, 1), with reset asynchronous and active-high.
REQ-006 SHALL have dispatch_en (input, 1): a dispatch request this cycle.
REQ-007 SHALL have dispatch_opcode (input, OPCODE_WIDTH) and dispatch_rd_tag (input, TAG_WIDTH): the operation and its destination tag.
REQ-008 SHALL have dispatch_rs1_data (input, DATA_WIDTH), dispatch_rs1_tag (input, TAG_WIDTH) and dispatch_rs1_valid (input, 1): source 1 operand; valid=1 means the data is present.
REQ-009 SHALL have dispatch_rs2_data, dispatch_rs2_tag and dispatch_rs2_valid with the same widths and meanings for source 2.
REQ-010 SHALL have issueque_full (output, 1): no free entry.
REQ-011 SHALL have issueque_count (output, clog2(DEPTH+1)): the number of occupied entries.
REQ-012 SHALL have CDB_valid (input, 1), CDB_tag (input, TAG_WIDTH) and CDB_data (input, DATA_WIDTH): the broadcast result.
REQ-013 SHALL have flush (input, 1): branch-mispredict squash.
REQ-014 SHALL have issue_ready (input, 1): the functional unit accepts an instruction.
REQ-015 SHALL have issue_valid (output, 1), issue_opcode, issue_rd_tag, issue_rs1_data and issue_rs2_data: the selected instruction.

Function
REQ-016 SHALL be a collapsing queue: entry 0 is oldest; occupied entries are contiguous from index 0.
REQ-017 SHALL form issueque_full as issueque_count==DEPTH, decoded from registered state only.
REQ-018 SHALL accept a dispatch when dispatch_en=1 and issueque_full=0, writing the entry at the tail.
  - Tail = count, or count-1 when an issue occurs in the same cycle.
REQ-019 SHALL ignore dispatch_en while full, even if an issue frees an entry that same cycle; no entry changes.
REQ-020 SHALL treat an entry as ready when both source-valid bits are 1.
REQ-021 SHALL select the lowest-index ready entry, with no ready entry giving issue_valid=0.
  - Issue outputs are combinational from the entry array.
  - Issue outputs are all-zero when issue_valid=0.
REQ-022 SHALL remove the selected entry on a clock edge with issue_valid and issue_ready both 1.
  - Younger entries shift down one index, preserving age order.
REQ-023 SHALL, when CDB_valid=1, capture CDB_data on every occupied entry with a source valid=0 and a tag equal to CDB_tag.
  - The source valid bit is set at the same edge.
  - The entry is issuable the next cycle.
REQ-024 SHALL apply the same CDB match to the instruction being dispatched (dispatch-time bypass), so it enters with the captured source already valid.
REQ-025 SHALL leave already-valid sources untouched by CDB_tag matches.
REQ-026 SHALL have a dispatch-to-issue latency of 1 cycle minimum: dispatch at edge N gives earliest issue_valid in the cycle after N.
REQ-027 SHALL, on flush=1, invalidate all entries at the next edge with count=0; flush dominates dispatch, issue and CDB capture.
REQ-028 SHALL update the count as +1 on accepted dispatch, -1 on an issue handshake, and 0 net when both occur; it never exceeds DEPTH and never underflows.

Reset
REQ-029 SHALL, on reset assertion and independent of clk, clear all entry valid bits, set count=0 and issueque_full=0, and drive issue_valid=0 with all issue data outputs 0.
REQ-030 SHALL discard any in-flight dispatch or issue handshake when reset asserts mid-operation, and start empty after deassertion.

Structure
REQ-031 SHALL take default TAG_WIDTH, OPCODE_WIDTH and DATA_WIDTH constants, plus the entry field layout (valid, opcode, rd_tag, rs1/rs2 tag/valid/data), from shared package dispatch_pkg, which Dispatch_Unit also uses.
REQ-032 SHALL place lowest-index-ready selection (DEPTH-bit ready vector in, one-hot grant plus any-ready out) in sub-module iq_select.

Verification (DEPTH=4)
REQ-033 SHALL cover dispatch of 4 ready ops (rd_tags 1..4) with issue_ready=0, then a 5th: full=1, count=4, 5th dropped; issue_ready=1 then issues tags 1,2,3,4 on consecutive cycles.
REQ-034 SHALL cover dispatch of rd_tag 7 with rs1_tag=5 not valid, then CDB_valid=1, CDB_tag=5, CDB_data=0xDEADBEEF: issue_valid=1 next cycle with rs1_data=0xDEADBEEF.
REQ-035 SHALL cover dispatch and CDB broadcast of the same rs2 tag in one cycle: the entry issues next cycle with the CDB value (bypass).
REQ-036 SHALL cover entry 0 waiting on a tag with entry 1 ready: entry 1 issues first, then entry 0 shifts and remains at index 0.
REQ-037 SHALL cover queue count=3 with flush, dispatch_en and issue_ready all 1: after the edge count=0 and issue_valid=0.
REQ-038 SHALL cover reset asserted asynchronously between edges with count=2: issueque_full=0, count=0 and issue_valid=0 immediately.
